// File: rtl/spi_slave_rx_if.sv
// Bundle of the SPI line and word-output handshake signals for spi_slave_rx.
//   sclk, cs, mosi : SPI lines from the remote master (cs active low)
//   dout_ready     : consumer accepts the presented word
//   dout           : received word, stable while dout_valid is high
//   dout_valid     : word available
//   frame_err      : one-cycle pulse, frame ended with the wrong bit count
//   overrun        : one-cycle pulse, good frame dropped because the slot was full
//   busy           : frame in progress
// Modport slave is the receiver; modport master is the side that drives the
// SPI lines and consumes words (the environment around the receiver).
interface spi_slave_rx_if #(
  parameter int unsigned DATA_W = 12
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport slave (
    input  sclk, cs, mosi, dout_ready,
    output dout, dout_valid, frame_err, overrun, busy
  );

  modport master (
    output sclk, cs, mosi, dout_ready,
    input  dout, dout_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave receiver. Oversamples sclk/cs/mosi on clk, deserialises LSB-first
// frames of DATA_W bits and presents each good word on a valid/ready slot.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : spi_slave_rx_if.slave (SPI lines in, word/handshake/status out)
module spi_slave_rx #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SKIP_EDGES  = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_rx_if.slave bus
);

  localparam int unsigned CntW     = $clog2(DATA_W + 2);
  localparam int unsigned SkipW    = (SKIP_EDGES > 1) ? $clog2(SKIP_EDGES) : 1;
  localparam int unsigned SkipLast = (SKIP_EDGES > 0) ? SKIP_EDGES - 1 : 0;
  localparam int unsigned ArmW     = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {StArm, StIdle, StSkip, StShift} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                sclk_prev_q, cs_prev_q;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     bitcnt_q, bitcnt_d;
  logic [SkipW-1:0]    skip_cnt_q, skip_cnt_d;
  logic [ArmW-1:0]     arm_cnt_q, arm_cnt_d;
  logic                commit_q, commit_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic sclk_now, cs_now, mosi_now;
  logic sclk_fall, cs_fall, cs_rise;

  assign sclk_now  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_now    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_now  = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_now;
  assign cs_fall   = cs_prev_q & ~cs_now;
  assign cs_rise   = ~cs_prev_q & cs_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StArm;
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      skip_cnt_q   <= '0;
      arm_cnt_q    <= '0;
      commit_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q  <= sclk_now;
      cs_prev_q    <= cs_now;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      skip_cnt_q   <= skip_cnt_d;
      arm_cnt_q    <= arm_cnt_d;
      commit_q     <= commit_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    skip_cnt_d   = skip_cnt_q;
    arm_cnt_d    = arm_cnt_q;
    commit_d     = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    unique case (state_q)
      StArm: begin
        // The cs chain resets to 1, so its first SYNC_STAGES outputs are stale.
        // Require one more cycle of high cs before trusting it.
        if (cs_now) begin
          if (arm_cnt_q == ArmW'(SYNC_STAGES)) begin
            state_d   = StIdle;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end else begin
          arm_cnt_d = '0;
        end
      end
      StIdle: begin
        if (cs_fall) begin
          shift_d    = '0;
          bitcnt_d   = '0;
          skip_cnt_d = '0;
          state_d    = (SKIP_EDGES == 0) ? StShift : StSkip;
        end
      end
      StSkip: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end else if (sclk_fall) begin
          if (skip_cnt_q == SkipW'(SkipLast)) begin
            state_d = StShift;
          end else begin
            skip_cnt_d = skip_cnt_q + 1'b1;
          end
        end
      end
      StShift: begin
        if (sclk_fall) begin
          shift_d = {mosi_now, shift_q[DATA_W-1:1]};
          if (bitcnt_q != CntW'(DATA_W + 1)) begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
        // Uses bitcnt_d so a final edge coincident with cs_rise is counted.
        if (cs_rise) begin
          state_d = StIdle;
          if (bitcnt_d == CntW'(DATA_W)) begin
            commit_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = StArm;
    endcase

    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
    if (commit_q) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = shift_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q == StSkip) || (state_q == StShift);

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI receiver (slave end) for the team's 12-bit SPI master. Samples the master's sclk/cs/mosi on the local system clock, deserialises LSB-first frames, and presents each complete word on a valid/ready output port.
- Flags malformed frames (wrong bit count) and overruns (new word arriving while the previous word is still unaccepted).
- Sits on the receive side of the SPI link, feeding a register file or FIFO in the same clk domain.

Parameters:
- DATA_W, 12, frame length in bits. Equals the master's din width.
- SKIP_EDGES, 1, number of leading sclk falling edges after cs assertion that are discarded. The master drives bit0 one sclk rising edge after asserting cs, so the first falling edge carries no data.
- SYNC_STAGES, 2, flop depth of the input synchronisers on sclk, cs and mosi. Minimum 2.

Ports:
- clk  in  1  system clock. Same frequency as the master's clk; sclk half-period is at least 8 clk cycles.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI serial clock from the master. Asynchronous; synchronised internally.
- cs  in  1  SPI chip select, active low.
- mosi  in  1  SPI serial data, LSB first.
- dout  out  DATA_W  received word. Stable while dout_valid is high.
- dout_valid  out  1  word available.
- dout_ready  in  1  consumer accepts the word.
- frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than DATA_W.
- overrun  out  1  one-cycle pulse when a good frame is dropped because the output slot is occupied.
- busy  out  1  high while a frame is in progress (state SKIP or SHIFT).

Behaviour:
- Reset values: dout=0, dout_valid=0, frame_err=0, overrun=0, busy=0, shift register=0, bit counter=0, state=ARM.
- Synchroniser reset values: cs chain resets to 1, sclk and mosi chains to 0.
- Edge detect: compare the last synchroniser stage with a one-cycle-delayed copy.
  - sclk_fall = prev 1, now 0.
  - cs_fall and cs_rise are defined the same way on cs.
  - mosi is sampled from its synchronised stage in the same cycle sclk_fall is detected. All three paths use equal synchroniser depth, so there is no skew.
- FSM:
  - ARM: entered on reset. Waits for synced cs==1 for at least one cycle, then goes to IDLE. This prevents a cs held low across reset from starting a false frame.
  - IDLE: on cs_fall, clear the shift register and counters, then go to SKIP. If SKIP_EDGES==0, go directly to SHIFT.
  - SKIP: count sclk_fall events. After SKIP_EDGES of them, go to SHIFT. A cs_rise here ends a 0-bit frame: pulse frame_err, go to IDLE.
  - SHIFT: on each sclk_fall:
    - Shift right with mosi entering at bit DATA_W-1, so the first bit received ends in bit0.
    - Increment bitcnt, saturating at DATA_W+1.
  - On cs_rise in SHIFT, go to IDLE.
    - If bitcnt==DATA_W: commit the frame.
    - Otherwise (short or long frame): pulse frame_err and discard. dout/dout_valid are unchanged.
- Simultaneous sclk_fall and cs_rise in the same cycle: process the sclk_fall first, then evaluate bitcnt for the cs_rise.
- Commit, in the cycle after the cs_rise detection cycle:
  - If dout_valid==0, or dout_valid==1 with dout_ready==1 in that same cycle: load dout with the shift register and set dout_valid=1.
  - Otherwise keep the old dout/dout_valid and pulse overrun for one cycle.
- Handshake: dout_valid stays high until a cycle with dout_ready=1. It deasserts the cycle after, unless a commit reloads it in that same cycle.
- Latency: the word is visible SYNC_STAGES+2 clk cycles after the master's cs rising edge.
- busy is high in SKIP and SHIFT, low in ARM and IDLE.
- Reset asserted mid-frame: the partial frame is lost, no frame_err or overrun is raised, and the block re-enters ARM.

Test Plan:
- Single frame: master sends din=12'hA5C. Expect dout=12'hA5C, dout_valid=1, frame_err=0, dout_valid held until dout_ready=1.
- Back-to-back frames 12'h001 and 12'h800 with dout_ready tied high. Expect two valid words in order, exercising the LSB and MSB positions.
- Overrun: send 12'h123, keep dout_ready=0, send 12'hFED. Expect a one-cycle overrun pulse, dout remains 12'h123; after one dout_ready pulse, dout_valid drops.
- Short frame: raise cs after 7 data falling edges. Expect a frame_err pulse, dout_valid stays 0. A following good frame 12'h5A5 is received correctly.
- Long frame: 13 data falling edges before cs rises. Expect frame_err, no commit.
- Reset mid-frame: assert rst for 2 cycles after 5 bits of 12'hFFF while cs stays low. Expect no output and no error flags; the block waits in ARM until cs goes high, then the next frame 12'h3C3 is received correctly.
